// File: rtl/rawp_stream_writer.sv
`timescale 1ns/1ps
// rawp_stream_writer
// Packs a byte stream (valid/ready/last) little-endian into 32-bit words and
// writes them to consecutive word addresses of the DMA RAM raw port, starting
// at a programmed base. Reports stored byte count and error status per frame.
//
// Ports
//   rawp_clk, rawp_rst_n        clock, synchronous active-low reset
//   cmd_start/base/max_len      frame command (honoured only when idle)
//   s_data/s_valid/s_last       byte stream in; s_ready out (state-decoded)
//   rawp_adr_o/dat_o/we_o       RAM write port (byte address, [1:0] = 0)
//   rawp_stall_i                RAM stall, valid the cycle after a write
//   busy, done, done_len, done_err  frame status
module rawp_stream_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  rawp_clk,
  input  logic                  rawp_rst_n,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_max_len,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] rawp_adr_o,
  output logic [31:0]           rawp_dat_o,
  output logic                  rawp_we_o,
  input  logic                  rawp_stall_i,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  done_len,
  output logic                  done_err
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DRAIN, S_WAIT1, S_WAIT2} state_e;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = 1;
  localparam logic [ADDR_WIDTH-3:0] WIDX_ONE   = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  max_len_q, max_len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           acc_q, acc_d;
  logic [ADDR_WIDTH-3:0] word_idx_q, word_idx_d;
  logic                  err_q, err_d;
  logic                  stall_chk_q;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  done_len_q, done_len_d;
  logic                  done_err_q, done_err_d;

  logic                  accept;
  logic                  in_range;
  logic [31:0]           acc_ins;
  logic [ADDR_WIDTH-1:0] word_adr;

  assign accept   = s_valid & s_ready;
  assign in_range = count_q < max_len_q;
  // Current byte merged into its lane of the accumulator.
  assign acc_ins  = acc_q | ({24'd0, s_data} << {lane_q, 3'b000});
  // Wraps modulo 2^ADDR_WIDTH by truncation.
  assign word_adr = base_q + {word_idx_q, 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge rawp_clk) begin
    if (!rawp_rst_n) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_start) state_d = S_RECV;
      S_RECV: begin
        if (accept && s_last)         state_d = S_WAIT1;
        else if (accept && !in_range) state_d = S_DRAIN;
      end
      S_DRAIN: if (accept && s_last) state_d = S_WAIT1;
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: ready depends on state only, never on s_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = (state_q == S_RECV) || (state_q == S_DRAIN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    base_d     = base_q;
    max_len_d  = max_len_q;
    count_d    = count_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_len_d = done_len_q;
    done_err_d = done_err_q;
    // The stall of a write is only meaningful in the cycle after it.
    err_d      = err_q | (stall_chk_q & rawp_stall_i);

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          base_d     = cmd_base & ALIGN_MASK;
          max_len_d  = cmd_max_len;
          count_d    = '0;
          lane_d     = '0;
          acc_d      = '0;
          word_idx_d = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RECV: begin
        if (accept) begin
          if (in_range) begin
            count_d = count_q + LEN_ONE;
            if (lane_q == 2'd3 || s_last) begin
              we_d       = 1'b1;
              adr_d      = word_adr;
              dat_d      = acc_ins;
              word_idx_d = word_idx_q + WIDX_ONE;
              lane_d     = '0;
              acc_d      = '0;
            end else begin
              lane_d = lane_q + 2'd1;
              acc_d  = acc_ins;
            end
          end else begin
            // Overflow: drop the byte, flush whatever partial word is held.
            err_d = 1'b1;
            if (lane_q != 2'd0) begin
              we_d       = 1'b1;
              adr_d      = word_adr;
              dat_d      = acc_q;
              word_idx_d = word_idx_q + WIDX_ONE;
              lane_d     = '0;
              acc_d      = '0;
            end
          end
        end
      end
      S_WAIT2: begin
        done_d     = 1'b1;
        done_len_d = count_q;
        done_err_d = err_d;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rawp_clk) begin
    if (!rawp_rst_n) begin
      base_q      <= '0;
      max_len_q   <= '0;
      count_q     <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      word_idx_q  <= '0;
      err_q       <= 1'b0;
      stall_chk_q <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_len_q  <= '0;
      done_err_q  <= 1'b0;
    end else begin
      base_q      <= base_d;
      max_len_q   <= max_len_d;
      count_q     <= count_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      word_idx_q  <= word_idx_d;
      err_q       <= err_d;
      stall_chk_q <= we_q;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_len_q  <= done_len_d;
      done_err_q  <= done_err_d;
    end
  end

  assign rawp_we_o  = we_q;
  assign rawp_adr_o = adr_q;
  assign rawp_dat_o = dat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_len   = done_len_q;
  assign done_err   = done_err_q;

endmodule
